// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: steps a per-direction frame index on held frame
// ticks in loop, ping-pong or one-shot mode, with a shoot pose override.
module sprite_anim_seq #(
  parameter  int FRAMES = 6,
  parameter  int HOLD   = 10,
  localparam int FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int IDW    = $clog2(2*FRAMES+2)
) (
  input  logic           frame_clk,
  input  logic           Reset,
  input  logic           enable,
  input  logic           direction,
  input  logic [1:0]     mode,
  input  logic           shoot,
  input  logic           restart,
  output logic [FW-1:0]  frame,
  output logic           dir_q,
  output logic           shooting,
  output logic [IDW-1:0] sprite_id,
  output logic           done,
  output logic           busy
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(HOLD-1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES-1);

  typedef enum logic [1:0] {
    MODE_LOOP    = 2'b00,
    MODE_PING    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_LOOP_B  = 2'b11
  } mode_e;

  mode_e         w_mode;
  logic [FW-1:0] r_frame;
  logic [CW-1:0] r_cnt;
  logic          r_dir_q;
  logic          r_pp_up;
  logic          r_finished;
  logic          r_shooting;
  logic          r_done;

  assign w_mode = mode_e'(mode);

  // NOTE: all state registers use non-blocking assignments so every branch
  // reads the pre-edge values and later writes cleanly override earlier ones.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_frame    <= '0;
      r_cnt      <= '0;
      r_dir_q    <= 1'b0;
      r_pp_up    <= 1'b1;
      r_finished <= 1'b0;
      r_shooting <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (restart) begin
        r_frame    <= '0;
        r_cnt      <= '0;
        r_pp_up    <= 1'b1;
        r_finished <= 1'b0;
        r_shooting <= 1'b0;
      end else begin
        if (w_mode != MODE_ONESHOT) r_finished <= 1'b0;
        if (direction != r_dir_q) begin
          r_dir_q    <= direction;
          r_frame    <= '0;
          r_cnt      <= '0;
          r_pp_up    <= 1'b1;
          r_finished <= 1'b0;
          r_shooting <= shoot;
        end else if (shoot) begin
          // Pose override freezes the frame and discards partial hold time.
          r_shooting <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_shooting <= 1'b0;
          if (enable) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              case (w_mode)
                MODE_PING: begin
                  if (FRAMES > 1) begin
                    if (r_pp_up && r_frame == FRAME_LAST) begin
                      r_pp_up <= 1'b0;
                      r_frame <= r_frame - 1'b1;
                    end else if (!r_pp_up && r_frame == '0) begin
                      r_pp_up <= 1'b1;
                      r_frame <= FW'(1);
                    end else begin
                      r_frame <= r_pp_up ? r_frame + 1'b1 : r_frame - 1'b1;
                    end
                  end
                end
                MODE_ONESHOT: begin
                  if (r_frame != FRAME_LAST) begin
                    r_frame <= r_frame + 1'b1;
                  end else if (!r_finished) begin
                    r_finished <= 1'b1;
                    r_done     <= 1'b1;
                  end
                end
                default: r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
              endcase
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  // NOTE: sprite_id gets a value on every path so no latch is inferred.
  always_comb begin
    sprite_id = '0;
    if (r_shooting) begin
      sprite_id = IDW'(2*FRAMES) + IDW'(r_dir_q);
    end else begin
      sprite_id = (r_dir_q ? IDW'(FRAMES) : '0) + IDW'(r_frame);
    end
  end

  assign frame    = r_frame;
  assign dir_q    = r_dir_q;
  assign shooting = r_shooting;
  assign done     = r_done;
  assign busy     = !r_finished;

endmodule
